// File: rtl/compressor_harness_pkg.sv
// Shared types and helpers for the compressor test harness serializers.
// Holds the serializer state encoding and the counter sizing rule.
package compressor_harness_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_RESULT_WIDTH = 38;

  // A counter never collapses to zero bits, even for degenerate widths.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/compressor_result_serializer.sv
// Parallel-in/serial-out stage for compressor results: captures dst0..dst<WIDTH-1>
// on a valid/ready load and shifts them out LSB first, with a shift-enable stall.
module compressor_result_serializer
  import compressor_harness_pkg::*;
#(
  parameter int WIDTH = DEFAULT_RESULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic in_shift;
  logic at_last;
  logic load_acc;

  assign in_shift = (state_q == SHIFT);
  assign at_last  = in_shift && (cnt_q == LAST_CNT);

  // Ready on the final bit only when that bit is actually consumed, so a
  // stalled last bit cannot be overwritten.
  assign load_ready = !rst && ((state_q == IDLE) || (at_last && shift_en));
  assign load_acc   = load_valid && load_ready;

  assign dout       = in_shift ? sreg_q[0] : 1'b0;
  assign dout_valid = in_shift;
  assign busy       = in_shift;
  assign dout_last  = at_last;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q == LAST_CNT) begin
            if (load_acc) begin
              sreg_d = din;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_compressor_result_serializer.sv
// Scoreboard bench for compressor_result_serializer: a 38-bit and a 2-bit instance,
// expected bits queued at each accepted load and popped as the pin advances.
module tb_compressor_result_serializer;

  localparam int W_A = 38;
  localparam int W_B = 2;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a = 1'b1, lv_a = 1'b0, se_a = 1'b0;
  logic [W_A-1:0] din_a = '0;
  logic           lr_a, dout_a, dv_a, dl_a, busy_a;

  logic           rst_b = 1'b1, lv_b = 1'b0, se_b = 1'b0;
  logic [W_B-1:0] din_b = '0;
  logic           lr_b, dout_b, dv_b, dl_b, busy_b;

  int checks = 0;
  int errors = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  compressor_result_serializer #(.WIDTH(W_A)) dut_a (
    .clk(clk), .rst(rst_a), .load_valid(lv_a), .load_ready(lr_a), .din(din_a),
    .shift_en(se_a), .dout(dout_a), .dout_valid(dv_a), .dout_last(dl_a), .busy(busy_a)
  );

  compressor_result_serializer #(.WIDTH(W_B)) dut_b (
    .clk(clk), .rst(rst_b), .load_valid(lv_b), .load_ready(lr_b), .din(din_b),
    .shift_en(se_b), .dout(dout_b), .dout_valid(dv_b), .dout_last(dl_b), .busy(busy_b)
  );

  // One clock: scoreboard pop/push on the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_a) begin
      if (dv_a === 1'b1 && se_a) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL a_extra_bit: dout=%b with no expected bit queued", dout_a);
        end else begin
          e = sb_a.pop_front();
          if (dout_a !== e.b || dl_a !== e.last) begin
            errors++;
            $display("FAIL a_stream: dout=%b last=%b expected dout=%b last=%b", dout_a, dl_a, e.b, e.last);
          end
        end
      end
      if (lv_a && lr_a === 1'b1)
        for (int i = 0; i < W_A; i++) sb_a.push_back('{din_a[i], (i == W_A - 1)});
    end
    if (!rst_b) begin
      if (dv_b === 1'b1 && se_b) begin
        checks++;
        if (sb_b.size() == 0) begin
          errors++;
          $display("FAIL b_extra_bit: dout=%b with no expected bit queued", dout_b);
        end else begin
          e = sb_b.pop_front();
          if (dout_b !== e.b || dl_b !== e.last) begin
            errors++;
            $display("FAIL b_stream: dout=%b last=%b expected dout=%b last=%b", dout_b, dl_b, e.b, e.last);
          end
        end
      end
      if (lv_b && lr_b === 1'b1)
        for (int i = 0; i < W_B; i++) sb_b.push_back('{din_b[i], (i == W_B - 1)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; lv_a = 1'b0; se_a = 1'b0;
    tick();
    checks++;
    if (lr_a !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in_rst: load_ready=%b expected 0", lr_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if ({dout_a, dv_a, dl_a, busy_a, lr_a} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_outputs: dout/valid/last/busy/ready=%b expected 00001",
               {dout_a, dv_a, dl_a, busy_a, lr_a});
    end
  endtask

  task automatic test_single();
    int nvalid = 0;
    int last_idx = -1;
    int nlast = 0;
    logic [63:0] r;
    din_a = 38'h2_A5A5_A5A5; lv_a = 1'b1; se_a = 1'b1;
    tick();
    r = {$urandom(), $urandom()};
    lv_a = 1'b0; din_a = r[W_A-1:0];
    for (int i = 0; i < 60; i++) begin
      if (dv_a) nvalid++;
      if (dl_a) begin nlast++; last_idx = i; end
      tick();
    end
    checks++;
    if (nvalid != W_A) begin
      errors++; $display("FAIL single_valid_len: got %0d cycles expected %0d", nvalid, W_A);
    end
    checks++;
    if (nlast != 1 || last_idx != W_A - 1) begin
      errors++; $display("FAIL single_last: count=%0d at %0d expected 1 at %0d", nlast, last_idx, W_A - 1);
    end
    checks++;
    if (dv_a !== 1'b0 || lr_a !== 1'b1 || sb_a.size() != 0) begin
      errors++; $display("FAIL single_idle: valid=%b ready=%b queued=%0d expected 0 1 0", dv_a, lr_a, sb_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int nready = 0;
    logic acc;
    din_a = 38'h00_0000_0001; lv_a = 1'b1; se_a = 1'b1;
    tick();
    din_a = 38'h3F_FFFF_FFFF;
    for (int i = 0; i < 2 * W_A; i++) begin
      checks++;
      if (dv_a !== 1'b1) begin
        errors++; $display("FAIL b2b_gap: valid=%b at bit %0d expected 1", dv_a, i);
      end
      checks++;
      if (lr_a !== ((i == W_A - 1) || (i == 2 * W_A - 1))) begin
        errors++; $display("FAIL b2b_ready: ready=%b at bit %0d", lr_a, i);
      end
      if (lr_a) nready++;
      acc = lv_a && lr_a;
      tick();
      if (acc) lv_a = 1'b0;
    end
    checks++;
    if (nready != 2 || dv_a !== 1'b0 || sb_a.size() != 0) begin
      errors++; $display("FAIL b2b_end: pulses=%0d valid=%b queued=%0d expected 2 0 0", nready, dv_a, sb_a.size());
    end
  endtask

  task automatic test_stall();
    int nen = 0;
    logic [W_A-1:0] word;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    word = r[W_A-1:0];
    din_a = word; lv_a = 1'b1; se_a = 1'b1;
    tick();
    lv_a = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    se_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (dout_a !== word[10] || dv_a !== 1'b1 || dl_a !== 1'b0 || lr_a !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: dout=%b valid=%b last=%b ready=%b expected %b 1 0 0",
                 dout_a, dv_a, dl_a, lr_a, word[10]);
      end
      tick();
    end
    se_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (dv_a) nen++;
      tick();
    end
    checks++;
    if (nen + 10 != W_A || sb_a.size() != 0) begin
      errors++; $display("FAIL stall_len: enabled=%0d queued=%0d expected %0d 0", nen + 10, sb_a.size(), W_A);
    end
  endtask

  task automatic test_mid_load();
    logic [W_A-1:0] word;
    logic [63:0] r;
    logic acc;
    r = {$urandom(), $urandom()};
    word = r[W_A-1:0];
    din_a = word; lv_a = 1'b1; se_a = 1'b1;
    tick();
    lv_a = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    din_a = 38'h15; lv_a = 1'b1;
    for (int i = 20; i < W_A; i++) begin
      checks++;
      if (lr_a !== (i == W_A - 1)) begin
        errors++; $display("FAIL midload_ready: ready=%b at bit %0d", lr_a, i);
      end
      acc = lv_a && lr_a;
      tick();
      if (acc) lv_a = 1'b0;
    end
    for (int i = 0; i < W_A + 2; i++) tick();
    checks++;
    if (lv_a !== 1'b0 || dv_a !== 1'b0 || sb_a.size() != 0) begin
      errors++; $display("FAIL midload_end: pending=%b valid=%b queued=%0d expected 0 0 0", lv_a, dv_a, sb_a.size());
    end
    lv_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W_A-1:0] w1, w2;
    logic [63:0] r;
    r = {$urandom(), $urandom()}; w1 = r[W_A-1:0];
    r = {$urandom(), $urandom()}; w2 = r[W_A-1:0] | 38'h1;
    din_a = w1; lv_a = 1'b1; se_a = 1'b1;
    tick();
    lv_a = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst_a = 1'b1; se_a = 1'b0;
    #1;
    checks++;
    if (lr_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready_in_rst: ready=%b expected 0", lr_a);
    end
    tick();
    rst_a = 1'b0;
    sb_a.delete();
    #1;
    checks++;
    if ({dout_a, dv_a, dl_a, busy_a, lr_a} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_outputs: dout/valid/last/busy/ready=%b expected 00001",
               {dout_a, dv_a, dl_a, busy_a, lr_a});
    end
    din_a = w2; lv_a = 1'b1; se_a = 1'b1;
    tick();
    lv_a = 1'b0;
    checks++;
    if (dout_a !== 1'b1 || dv_a !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart: dout=%b valid=%b expected 1 1", dout_a, dv_a);
    end
    for (int i = 0; i < W_A + 2; i++) tick();
    checks++;
    if (sb_a.size() != 0 || dv_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_end: queued=%0d valid=%b expected 0 0", sb_a.size(), dv_a);
    end
  endtask

  task automatic test_width2();
    logic [3:0] exp_d, exp_l;
    logic acc;
    exp_d = 4'b1010;
    exp_l = 4'b1010;
    rst_b = 1'b1; lv_b = 1'b0; se_b = 1'b0;
    tick();
    rst_b = 1'b0;
    din_b = 2'b10; lv_b = 1'b1; se_b = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_b !== exp_d[i] || dl_b !== exp_l[i] || dv_b !== 1'b1 || lr_b !== exp_l[i]) begin
        errors++;
        $display("FAIL w2_bit%0d: dout=%b last=%b valid=%b ready=%b expected %b %b 1 %b",
                 i, dout_b, dl_b, dv_b, lr_b, exp_d[i], exp_l[i], exp_l[i]);
      end
      acc = lv_b && lr_b;
      tick();
      if (acc && i == 1) lv_b = 1'b0;
    end
    checks++;
    if (dv_b !== 1'b0 || lr_b !== 1'b1 || sb_b.size() != 0) begin
      errors++; $display("FAIL w2_end: valid=%b ready=%b queued=%0d expected 0 1 0", dv_b, lr_b, sb_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_mid_load();
    test_reset_mid();
    test_width2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
